// File: rtl/mpeg_frame_scheduler_pkg.sv
// Shared MPEG frame-buffer types: planar YUV descriptor, index width
// and buffer address helpers used by the frame scheduler and its queue.
package mpeg_frame_scheduler_pkg;

    localparam int ADR_W = 29;

    typedef struct packed {
        logic [ADR_W-1:0] y_adr;
        logic [ADR_W-1:0] u_adr;
        logic [ADR_W-1:0] v_adr;
        logic             first_intra_frame_of_gop;
    } planar_yuv_s;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Chroma planes follow luma back to back; all sums wrap at 2^29.
    function automatic planar_yuv_s frame_of(
        input logic [ADR_W-1:0] idx,
        input logic [ADR_W-1:0] base,
        input logic [ADR_W-1:0] y_size,
        input logic [ADR_W-1:0] stride,
        input logic             intra
    );
        planar_yuv_s f;
        f.y_adr = base + idx * stride;
        f.u_adr = f.y_adr + y_size;
        f.v_adr = f.u_adr + (y_size >> 2);
        f.first_intra_frame_of_gop = intra;
        return f;
    endfunction

endpackage

// File: rtl/mpeg_frame_queue.sv
// Synchronous FIFO of committed {idx, first_intra} entries with flush;
// head and valid are registered so the display side sees flop outputs.
module mpeg_frame_queue
    import mpeg_frame_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         valid,
    output logic [W-1:0] head
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] count, count_nxt, kept;
    logic [W-1:0]  head_nxt;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    always_comb begin
        rd_nxt    = do_pop  ? inc(rd_ptr) : rd_ptr;
        wr_nxt    = do_push ? inc(wr_ptr) : wr_ptr;
        kept      = count - CW'(do_pop);
        count_nxt = kept + CW'(do_push);
        head_nxt  = '0;
        if (flush) begin
            rd_nxt    = '0;
            wr_nxt    = '0;
            count_nxt = '0;
        end else if (count_nxt != '0) begin
            // Only the entry being written survives: forward it.
            head_nxt = (kept == '0) ? push_data : mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= count_nxt;
            valid  <= (count_nxt != '0);
            head   <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mpeg_frame_scheduler.sv
// Frame-buffer pool scheduler between MPEG decoder and display fetch.
// Optional MPEG_FRAME_SCHED_STATS_EN adds underrun/alloc-stall counters.
module mpeg_frame_scheduler
    import mpeg_frame_scheduler_pkg::*;
#(
    parameter int          NUM_FRAMES   = 4,
    parameter logic [28:0] BASE_ADR     = 29'h0,
    parameter logic [28:0] Y_SIZE       = 29'd101376,
    parameter logic [28:0] FRAME_STRIDE = 29'd152064,
    localparam int         IW           = idx_width(NUM_FRAMES),
    localparam int         CW           = $clog2(NUM_FRAMES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    output logic          alloc_ack,
    output logic [IW-1:0] alloc_idx,
    output planar_yuv_s   alloc_frame,
    input  logic          commit,
    input  logic [IW-1:0] commit_idx,
    input  logic          commit_first_intra,
    input  logic          dec_release,
    input  logic [IW-1:0] dec_release_idx,
    input  logic          flush,
    output logic          disp_valid,
    input  logic          disp_ready,
    output planar_yuv_s   disp_frame,
    output logic          cmd_error,
    output logic [CW-1:0] free_count
`ifdef MPEG_FRAME_SCHED_STATS_EN
    ,
    output logic [15:0]   underrun_count,
    output logic [15:0]   alloc_stall_count
`endif
);

    logic [NUM_FRAMES-1:0] dec_hold, dec_hold_nxt;
    logic [NUM_FRAMES-1:0] q_mask, q_mask_nxt;
    logic [NUM_FRAMES-1:0] cur_mask, cur_mask_nxt;
    logic [NUM_FRAMES-1:0] free_mask, free_nxt;
    logic                  cur_valid, cur_valid_nxt;
    logic [IW-1:0]         cur_idx, cur_idx_nxt;
    logic [IW-1:0]         free_idx;
    logic [CW-1:0]         free_cnt_nxt;
    logic                  any_free, alloc_go;
    logic                  commit_ok, rel_ok, do_push, do_pop;
    logic                  q_valid, head_intra;
    logic [IW-1:0]         head_idx;

    mpeg_frame_queue #(
        .DEPTH (NUM_FRAMES),
        .W     (IW + 1)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .push_data ({commit_idx, commit_first_intra}),
        .pop       (do_pop),
        .flush     (flush),
        .valid     (q_valid),
        .head      ({head_idx, head_intra})
    );

    // Lowest free index wins; disp_hold is queued-or-current.
    always_comb begin
        cur_mask = '0;
        if (cur_valid) cur_mask[cur_idx] = 1'b1;
        free_mask = ~(dec_hold | q_mask | cur_mask);
        any_free  = |free_mask;
        free_idx  = '0;
        for (int i = NUM_FRAMES - 1; i >= 0; i--) begin
            if (free_mask[i]) free_idx = IW'(i);
        end
    end

    always_comb begin
        alloc_go  = alloc_req && !alloc_ack && any_free;
        commit_ok = dec_hold[commit_idx] && !q_mask[commit_idx]
                    && !cur_mask[commit_idx];
        rel_ok    = dec_hold[dec_release_idx];
        do_push   = commit && commit_ok && !flush;
        do_pop    = q_valid && disp_ready && !flush;

        dec_hold_nxt = dec_hold;
        if (alloc_go) dec_hold_nxt[free_idx] = 1'b1;
        if (dec_release && rel_ok) dec_hold_nxt[dec_release_idx] = 1'b0;

        q_mask_nxt = q_mask;
        if (flush) begin
            q_mask_nxt = '0;
        end else begin
            if (do_pop)  q_mask_nxt[head_idx]   = 1'b0;
            if (do_push) q_mask_nxt[commit_idx] = 1'b1;
        end

        cur_valid_nxt = cur_valid || do_pop;
        cur_idx_nxt   = do_pop ? head_idx : cur_idx;
        cur_mask_nxt  = '0;
        if (cur_valid_nxt) cur_mask_nxt[cur_idx_nxt] = 1'b1;

        free_nxt     = ~(dec_hold_nxt | q_mask_nxt | cur_mask_nxt);
        free_cnt_nxt = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            free_cnt_nxt = free_cnt_nxt + CW'(free_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_hold    <= '0;
            q_mask      <= '0;
            cur_valid   <= 1'b0;
            cur_idx     <= '0;
            alloc_ack   <= 1'b0;
            alloc_idx   <= '0;
            alloc_frame <= '0;
            cmd_error   <= 1'b0;
            free_count  <= CW'(NUM_FRAMES);
        end else begin
            dec_hold   <= dec_hold_nxt;
            q_mask     <= q_mask_nxt;
            cur_valid  <= cur_valid_nxt;
            cur_idx    <= cur_idx_nxt;
            alloc_ack  <= alloc_go;
            cmd_error  <= (commit && !commit_ok)
                          || (dec_release && !rel_ok);
            free_count <= free_cnt_nxt;
            if (alloc_go) begin
                alloc_idx   <= free_idx;
                alloc_frame <= frame_of(ADR_W'(free_idx), BASE_ADR,
                                        Y_SIZE, FRAME_STRIDE, 1'b0);
            end
        end
    end

    assign disp_valid = q_valid;
    assign disp_frame = q_valid
        ? frame_of(ADR_W'(head_idx), BASE_ADR, Y_SIZE, FRAME_STRIDE,
                   head_intra)
        : '0;

`ifdef MPEG_FRAME_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count    <= '0;
            alloc_stall_count <= '0;
        end else begin
            if (disp_ready && !q_valid && underrun_count != '1)
                underrun_count <= underrun_count + 16'd1;
            if (alloc_req && !any_free && alloc_stall_count != '1)
                alloc_stall_count <= alloc_stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mpeg_frame_scheduler.sv
// Scoreboard bench for mpeg_frame_scheduler: directed alloc, commit,
// display, flush, error and reset scenarios with hand-computed values.
module tb_mpeg_frame_scheduler;
    import mpeg_frame_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alloc_req = 1'b0;
    logic        alloc_ack;
    logic [1:0]  alloc_idx;
    planar_yuv_s alloc_frame;
    logic        commit = 1'b0;
    logic [1:0]  commit_idx = '0;
    logic        commit_first_intra = 1'b0;
    logic        dec_release = 1'b0;
    logic [1:0]  dec_release_idx = '0;
    logic        flush = 1'b0;
    logic        disp_valid;
    logic        disp_ready = 1'b0;
    planar_yuv_s disp_frame;
    logic        cmd_error;
    logic [2:0]  free_count;
`ifdef MPEG_FRAME_SCHED_STATS_EN
    logic [15:0] underrun_count;
    logic [15:0] alloc_stall_count;
`endif

    mpeg_frame_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .alloc_req          (alloc_req),
        .alloc_ack          (alloc_ack),
        .alloc_idx          (alloc_idx),
        .alloc_frame        (alloc_frame),
        .commit             (commit),
        .commit_idx         (commit_idx),
        .commit_first_intra (commit_first_intra),
        .dec_release        (dec_release),
        .dec_release_idx    (dec_release_idx),
        .flush              (flush),
        .disp_valid         (disp_valid),
        .disp_ready         (disp_ready),
        .disp_frame         (disp_frame),
        .cmd_error          (cmd_error),
        .free_count         (free_count)
`ifdef MPEG_FRAME_SCHED_STATS_EN
        ,
        .underrun_count     (underrun_count),
        .alloc_stall_count  (alloc_stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int y;
        int u;
        int v;
        int intra;
    } exp_t;

    exp_t alloc_q[$];
    exp_t disp_q[$];
    int   err_q[$];
    exp_t ea, ed;
    int   compared = 0;
    int   mismatched = 0;

    int ytab[4] = '{0, 152064, 304128, 456192};
    int utab[4] = '{101376, 253440, 405504, 557568};
    int vtab[4] = '{126720, 278784, 430848, 582912};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int idx, input int intra);
        exp_t e;
        e.idx = idx;
        e.y = ytab[idx];
        e.u = utab[idx];
        e.v = vtab[idx];
        e.intra = intra;
        return e;
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (alloc_ack) begin
            if (alloc_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL alloc_unexpected: got idx %0d", alloc_idx);
            end else begin
                ea = alloc_q.pop_front();
                check("alloc_idx", 32'(alloc_idx), ea.idx);
                check("alloc_y", 32'(alloc_frame.y_adr), ea.y);
                check("alloc_u", 32'(alloc_frame.u_adr), ea.u);
                check("alloc_v", 32'(alloc_frame.v_adr), ea.v);
                check("alloc_intra",
                      32'(alloc_frame.first_intra_frame_of_gop), 0);
            end
        end
        if (disp_valid && disp_ready) begin
            if (disp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL disp_unexpected: got y %0d",
                         disp_frame.y_adr);
            end else begin
                ed = disp_q.pop_front();
                check("disp_y", 32'(disp_frame.y_adr), ed.y);
                check("disp_u", 32'(disp_frame.u_adr), ed.u);
                check("disp_v", 32'(disp_frame.v_adr), ed.v);
                check("disp_intra",
                      32'(disp_frame.first_intra_frame_of_gop), ed.intra);
            end
        end
        if (cmd_error) begin
            if (err_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL cmd_error_unexpected: got 1 expected 0");
            end else begin
                void'(err_q.pop_front());
            end
        end
    end

    task automatic do_alloc(input int idx);
        alloc_q.push_back(mk(idx, 0));
        alloc_req = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (alloc_ack) break;
        end
        check("alloc_ack_seen", 32'(alloc_ack), 1);
        alloc_req = 1'b0;
    endtask

    task automatic do_commit(input int idx, input logic intra);
        commit = 1'b1;
        commit_idx = 2'(idx);
        commit_first_intra = intra;
        tick();
        commit = 1'b0;
        commit_first_intra = 1'b0;
    endtask

    task automatic do_release(input int idx);
        dec_release = 1'b1;
        dec_release_idx = 2'(idx);
        tick();
        dec_release = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        check("rst_alloc_ack", 32'(alloc_ack), 0);
        check("rst_alloc_idx", 32'(alloc_idx), 0);
        check("rst_alloc_frame", 32'(alloc_frame != '0), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_disp_frame", 32'(disp_frame != '0), 0);
        check("rst_cmd_error", 32'(cmd_error), 0);
        check("rst_free_count", 32'(free_count), 4);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) do_alloc(i);
        check("free_after_fill", 32'(free_count), 0);

        alloc_req = 1'b1;
        repeat (3) tick();
        check("stall_no_ack", 32'(alloc_ack), 0);
        alloc_q.push_back(mk(1, 0));
        do_release(1);
        check("rel_ack_1cyc", 32'(alloc_ack), 0);
        tick();
        check("rel_ack_2cyc", 32'(alloc_ack), 1);
        alloc_req = 1'b0;
        tick();

        do_commit(0, 1'b0);
        do_commit(1, 1'b0);
        do_commit(2, 1'b0);
        check("queued_valid", 32'(disp_valid), 1);
        commit = 1'b1;
        commit_idx = 2'd3;
        flush = 1'b1;
        tick();
        commit = 1'b0;
        flush = 1'b0;
        check("flush_valid", 32'(disp_valid), 0);
        check("flush_free", 32'(free_count), 0);
        do_release(0);
        do_release(1);
        do_release(2);
        check("flush_freed", 32'(free_count), 3);
        do_release(3);
        check("flush_keep_dec", 32'(free_count), 4);

        do_alloc(0);
        do_alloc(1);
        do_alloc(2);
        disp_q.push_back(mk(2, 1));
        do_commit(2, 1'b1);
        disp_q.push_back(mk(0, 0));
        do_commit(0, 1'b0);
        do_release(2);
        check("disp_pending_free", 32'(free_count), 1);
        disp_ready = 1'b1;
        tick();
        check("pop1_free", 32'(free_count), 1);
        tick();
        disp_ready = 1'b0;
        check("pop2_free", 32'(free_count), 2);
        check("pop2_valid", 32'(disp_valid), 0);

        do_release(0);
        check("cur_held", 32'(free_count), 2);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("underrun_free", 32'(free_count), 2);
        check("underrun_valid", 32'(disp_valid), 0);
`ifdef MPEG_FRAME_SCHED_STATS_EN
        check("underrun_count", 32'(underrun_count), 1);
`endif

        err_q.push_back(1);
        do_commit(2, 1'b0);
        do_commit(1, 1'b0);
        err_q.push_back(1);
        do_commit(1, 1'b0);
        do_release(1);
        err_q.push_back(1);
        do_release(1);
        tick();
        check("err_pulse_end", 32'(cmd_error), 0);
        check("err_state_free", 32'(free_count), 2);

        do_alloc(2);
        do_alloc(3);
        check("refill_free", 32'(free_count), 0);
        alloc_req = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_alloc_ack", 32'(alloc_ack), 0);
        check("mid_rst_alloc_idx", 32'(alloc_idx), 0);
        check("mid_rst_alloc_frame", 32'(alloc_frame != '0), 0);
        check("mid_rst_disp_valid", 32'(disp_valid), 0);
        check("mid_rst_disp_frame", 32'(disp_frame != '0), 0);
        check("mid_rst_cmd_error", 32'(cmd_error), 0);
        check("mid_rst_free", 32'(free_count), 4);
        tick();
        alloc_q.push_back(mk(0, 0));
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (alloc_ack) break;
        end
        check("post_rst_ack", 32'(alloc_ack), 1);
        alloc_req = 1'b0;
        repeat (2) tick();

        check("alloc_pending", 32'(alloc_q.size()), 0);
        check("disp_pending", 32'(disp_q.size()), 0);
        check("err_pending", 32'(err_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
